filter_row_receiver: RTL and testbench

FILTER_ROW_RECEIVER -- requirements
Module: filter_row_receiver

---
 rtl/filter_row_receiver.sv | 138 +++++++++++++
 tb/tb_filter_row_receiver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_row_receiver.sv
// Filter row receiver: collects five 5-byte weight rows from the network into a
// 5x5 weight store and serves registered single-weight reads to the PE.
module filter_row_receiver #(
    parameter int NODE          = 1,
    parameter int WIDTH_packet  = 57,
    parameter int WIDTH_payload = 40,
    parameter int WIDTH_data    = 8,
    parameter int DEPTH_F       = 25
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH_packet-1:0] in_packet,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    consume,
    input  logic [4:0]              rd_addr,
    output logic [WIDTH_data-1:0]   rd_data,
    output logic                    filter_ready,
    output logic [4:0]              row_mask,
    output logic [7:0]              err_count
);

    localparam logic [3:0] NODE_ID  = 4'(NODE);
    localparam logic [3:0] ROW_TYPE = 4'h1;
    localparam int         ROW_LEN  = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        READY
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH_data-1:0]    mem [DEPTH_F];
    logic [3:0]               dest;
    logic [3:0]               pkt_type;
    logic [4:0]               seq;
    logic [WIDTH_payload-1:0] payload;
    logic [3:0]               unused_src;
    logic [4:0]               row_onehot;
    logic [4:0]               mask_next;
    logic                     accept;
    logic                     good;

    assign dest       = in_packet[WIDTH_packet-1 -: 4];
    assign unused_src = in_packet[WIDTH_packet-5 -: 4];
    assign pkt_type   = in_packet[WIDTH_payload+8 -: 4];
    assign seq        = in_packet[WIDTH_payload+4 -: 5];
    assign payload    = in_packet[WIDTH_payload-1:0];

    assign in_ready     = (state != READY);
    assign filter_ready = (state == READY);
    assign accept       = in_valid && in_ready;

    // Out-of-range row indices decode to no row, which makes them bad packets.
    always_comb begin
        row_onehot = '0;
        if (seq <= 5'd4) begin
            row_onehot = 5'b00001 << seq[2:0];
        end
    end

    assign mask_next = row_mask | row_onehot;
    assign good      = (dest == NODE_ID) && (pkt_type == ROW_TYPE)
                       && (row_onehot != '0) && ((row_mask & row_onehot) == '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, LOADING: begin
                if (accept && good) begin
                    state_next = (mask_next == 5'b11111) ? READY : LOADING;
                end
            end
            READY: begin
                if (consume) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Mask clears on release; weights themselves stay until overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_mask <= '0;
        end else if (state == READY && consume) begin
            row_mask <= '0;
        end else if (accept && good) begin
            row_mask <= mask_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (accept && !good && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

    // Entry i belongs to row i/5, column i%5; a good packet rewrites one whole row.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_F; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && good) begin
            for (int i = 0; i < DEPTH_F; i++) begin
                if (row_onehot[i/ROW_LEN]) begin
                    mem[i] <= payload[(i%ROW_LEN)*WIDTH_data +: WIDTH_data];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_addr < 5'(DEPTH_F)) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_filter_row_receiver.sv
// Directed self-checking bench for filter_row_receiver: loading, ordering,
// error counting, release handshake, reset and counter saturation.
module tb_filter_row_receiver;

    logic        clk;
    logic        reset;
    logic [56:0] in_packet;
    logic        in_valid;
    logic        in_ready;
    logic        consume;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        filter_ready;
    logic [4:0]  row_mask;
    logic [7:0]  err_count;

    int checks = 0;
    int passed = 0;

    filter_row_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .in_packet    (in_packet),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .consume      (consume),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .filter_ready (filter_ready),
        .row_mask     (row_mask),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [56:0] mkPkt(input logic [3:0] d, input logic [3:0] t,
                                          input logic [4:0] s, input logic [39:0] p);
        return {d, 4'h7, t, s, p};
    endfunction

    function automatic logic [39:0] rowPayload(input int r);
        logic [39:0] p;
        for (int k = 0; k < 5; k++) begin
            p[8*k +: 8] = 8'(5*r + k);
        end
        return p;
    endfunction

    function automatic logic [56:0] goodRow(input int r);
        return mkPkt(4'd1, 4'h1, 5'(r), rowPayload(r));
    endfunction

    // Inputs change 1ns after the rising edge, and registered outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [56:0] pkt);
        in_valid  = 1'b1;
        in_packet = pkt;
        step();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_packet = '0;
        in_valid  = 1'b0;
        consume   = 1'b0;
        rd_addr   = '0;
        step();
        step();
        reset = 1'b0;
        step();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_filter_ready", 32'(filter_ready), 32'd0);
        checkOutput("rst_row_mask", 32'(row_mask), 32'd0);
        checkOutput("rst_err", 32'(err_count), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);

        // In-order back-to-back load
        for (int r = 0; r < 5; r++) begin
            applyStimulus(goodRow(r));
            checkOutput("inorder_mask", 32'(row_mask), 32'((1 << (r + 1)) - 1));
            checkOutput("inorder_fready", 32'(filter_ready), (r == 4) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        checkOutput("inorder_in_ready", 32'(in_ready), 32'd0);
        checkOutput("inorder_err", 32'(err_count), 32'd0);
        for (int i = 0; i < 25; i++) begin
            rd_addr = 5'(i);
            step();
            checkOutput("inorder_read", 32'(rd_data), 32'(i));
        end
        rd_addr = 5'd25;
        step();
        checkOutput("read_addr25", 32'(rd_data), 32'd0);
        rd_addr = 5'd31;
        step();
        checkOutput("read_addr31", 32'(rd_data), 32'd0);

        // Consume in READY with a valid packet waiting
        applyStimulus(mkPkt(4'd1, 4'h1, 5'd2, 40'hA4A3A2A1A0));
        consume = 1'b1;
        step();
        consume = 1'b0;
        checkOutput("consume_in_ready", 32'(in_ready), 32'd1);
        checkOutput("consume_fready", 32'(filter_ready), 32'd0);
        checkOutput("consume_mask", 32'(row_mask), 32'd0);
        step();
        in_valid = 1'b0;
        checkOutput("after_consume_mask", 32'(row_mask), 32'b00100);
        checkOutput("after_consume_err", 32'(err_count), 32'd0);
        rd_addr = 5'd10;
        step();
        checkOutput("after_consume_row2", 32'(rd_data), 32'hA0);
        rd_addr = 5'd14;
        step();
        checkOutput("after_consume_row2c4", 32'(rd_data), 32'hA4);
        rd_addr = 5'd3;
        step();
        checkOutput("retained_row0", 32'(rd_data), 32'd3);

        // Out-of-order load after a fresh reset, with a read racing the row-0 write
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd_addr = 5'd2;
        applyStimulus(goodRow(4));
        checkOutput("ooo_mask_4", 32'(row_mask), 32'b10000);
        applyStimulus(goodRow(2));
        checkOutput("ooo_mask_2", 32'(row_mask), 32'b10100);
        applyStimulus(goodRow(0));
        checkOutput("ooo_mask_0", 32'(row_mask), 32'b10101);
        checkOutput("same_edge_old_value", 32'(rd_data), 32'd0);
        applyStimulus(goodRow(3));
        checkOutput("ooo_mask_3", 32'(row_mask), 32'b11101);
        checkOutput("read_after_write", 32'(rd_data), 32'd2);
        checkOutput("ooo_not_ready", 32'(filter_ready), 32'd0);
        applyStimulus(goodRow(1));
        in_valid = 1'b0;
        checkOutput("ooo_mask_1", 32'(row_mask), 32'b11111);
        checkOutput("ooo_fready", 32'(filter_ready), 32'd1);
        checkOutput("ooo_err", 32'(err_count), 32'd0);
        consume = 1'b1;
        step();
        consume = 1'b0;

        // Bad packets while loading
        applyStimulus(goodRow(0));
        applyStimulus(mkPkt(4'd2, 4'h1, 5'd1, rowPayload(1)));
        applyStimulus(mkPkt(4'd1, 4'h3, 5'd1, rowPayload(1)));
        applyStimulus(mkPkt(4'd1, 4'h1, 5'd7, rowPayload(1)));
        applyStimulus(mkPkt(4'd1, 4'h1, 5'd0, 40'hFFFFFFFFFF));
        in_valid = 1'b0;
        checkOutput("bad_err", 32'(err_count), 32'd4);
        checkOutput("bad_mask", 32'(row_mask), 32'b00001);
        checkOutput("bad_in_ready", 32'(in_ready), 32'd1);
        rd_addr = 5'd0;
        step();
        checkOutput("dup_row0_c0", 32'(rd_data), 32'd0);
        rd_addr = 5'd4;
        step();
        checkOutput("dup_row0_c4", 32'(rd_data), 32'd4);

        // Reset mid-load with a good packet presented
        applyStimulus(goodRow(1));
        applyStimulus(goodRow(2));
        checkOutput("preload_mask", 32'(row_mask), 32'b00111);
        reset = 1'b1;
        applyStimulus(goodRow(3));
        reset    = 1'b0;
        in_valid = 1'b0;
        checkOutput("midrst_mask", 32'(row_mask), 32'd0);
        checkOutput("midrst_err", 32'(err_count), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 25; i++) begin
            rd_addr = 5'(i);
            step();
            checkOutput("midrst_read", 32'(rd_data), 32'd0);
        end
        checkOutput("midrst_no_accept", 32'(row_mask), 32'd0);

        // Error counter saturation
        for (int n = 1; n <= 300; n++) begin
            applyStimulus(mkPkt(4'd2, 4'h1, 5'd0, 40'h0));
            if (n == 254) checkOutput("sat_254", 32'(err_count), 32'd254);
            if (n == 255) checkOutput("sat_255", 32'(err_count), 32'd255);
        end
        in_valid = 1'b0;
        checkOutput("sat_300", 32'(err_count), 32'd255);
        checkOutput("sat_mask", 32'(row_mask), 32'd0);
        checkOutput("sat_in_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
